// File: rtl/fsm_stream_ctrl_pkg.sv
// ============================================================================
// Module  : fsm_stream_ctrl_pkg
// Brief   : State encoding and default sizing for the detector stream sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_stream_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_DET_LAT = 1;
    localparam int DEFAULT_CNT_W   = 5;

endpackage

`default_nettype wire

// File: rtl/piso_shreg.sv
// ============================================================================
// Module  : piso_shreg
// Brief   : Parallel-load, MSB-first serial-out shift register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shreg
    import fsm_stream_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ser
);

    logic [WIDTH-1:0] r_shreg;

    // Load has priority so a start never races an in-flight shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign o_ser = r_shreg[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/fsm_stream_ctrl.sv
// ============================================================================
// Module  : fsm_stream_ctrl
// Brief   : Serialises a test word into an external sequence detector and
//           collects its delayed output into a match vector and count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_stream_ctrl
    import fsm_stream_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DET_LAT = DEFAULT_DET_LAT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data_in,
    output logic             o_det_in,
    input  logic             i_det_y,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_match_vec,
    output logic [CNT_W-1:0] o_match_cnt
);

    localparam int TICK_W = $clog2(WIDTH + DET_LAT + 1);

    localparam logic [TICK_W-1:0] c_SHIFT_LAST = TICK_W'(WIDTH - 1);
    localparam logic [TICK_W-1:0] c_DRAIN_LAST = TICK_W'(WIDTH + DET_LAT - 1);
    localparam logic [TICK_W-1:0] c_WIN_START  = TICK_W'(DET_LAT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_shift;
    logic              w_ser;
    logic              w_active;
    logic              w_sample;
    logic [TICK_W-1:0] r_tick;
    logic [WIDTH-1:0]  r_smp_mask;
    logic [WIDTH-1:0]  r_match_vec;
    logic [CNT_W-1:0]  r_match_cnt;

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_piso_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (i_data_in),
        .o_ser   (w_ser)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_tick == c_SHIFT_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_tick == c_DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One tick counter spans SHIFT and DRAIN; the detector latency only
    // shifts where the sampling window begins within it.
    assign w_active = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign w_sample = w_active && (r_tick >= c_WIN_START);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else if (w_load) begin
            r_tick <= '0;
        end else if (w_active) begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    // A walking one selects the data bit that the current sample belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_mask  <= '0;
            r_match_vec <= '0;
            r_match_cnt <= '0;
        end else if (w_load) begin
            r_smp_mask  <= {1'b1, {(WIDTH-1){1'b0}}};
            r_match_vec <= '0;
            r_match_cnt <= '0;
        end else if (w_sample) begin
            r_smp_mask <= r_smp_mask >> 1;
            if (i_det_y) begin
                r_match_vec <= r_match_vec | r_smp_mask;
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
        end
    end

    assign o_det_in    = (r_state == ST_SHIFT) && w_ser;
    assign o_busy      = w_active;
    assign o_done      = (r_state == ST_DONE);
    assign o_match_vec = r_match_vec;
    assign o_match_cnt = r_match_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fsm_stream_ctrl.sv
// ============================================================================
// Module  : tb_fsm_stream_ctrl
// Brief   : Self-checking bench driving two sequencers (detector latency 1 and 3).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fsm_stream_ctrl;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [W-1:0]  i_data;
    logic          det_in1, det_in3, det_y1, det_y3;
    logic          busy1, busy3, done1, done3;
    logic [W-1:0]  vec1, vec3;
    logic [CW-1:0] cnt1, cnt3;
    logic          det_mode, glitch;
    logic          stub1;
    logic [2:0]    dly3;
    logic [1:0]    fsm_st;
    logic          fsm_y;

    int n_checks = 0;
    int n_fail   = 0;
    int lat1, lat3, nd1, nd3, done1_at2;
    bit saw_det1, busy_bad;

    always #5 clk = ~clk;

    // Identity stubs: one-cycle register and three-stage delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stub1 <= 1'b0;
            dly3  <= '0;
        end else begin
            stub1 <= det_in1;
            dly3  <= {dly3[1:0], det_in3};
        end
    end

    // Overlapping "101" Moore detector with registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_st <= 2'd0;
            fsm_y  <= 1'b0;
        end else begin
            fsm_y <= (fsm_st == 2'd2) && det_in1;
            case (fsm_st)
                2'd0:    fsm_st <= det_in1 ? 2'd1 : 2'd0;
                2'd1:    fsm_st <= det_in1 ? 2'd1 : 2'd2;
                2'd2:    fsm_st <= det_in1 ? 2'd1 : 2'd0;
                default: fsm_st <= 2'd0;
            endcase
        end
    end

    assign det_y1 = (det_mode ? fsm_y : stub1) | glitch;
    assign det_y3 = dly3[2] | glitch;

    fsm_stream_ctrl #(.WIDTH(W), .DET_LAT(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_data_in(i_data),
        .o_det_in(det_in1), .i_det_y(det_y1), .o_busy(busy1), .o_done(done1),
        .o_match_vec(vec1), .o_match_cnt(cnt1)
    );

    fsm_stream_ctrl #(.WIDTH(W), .DET_LAT(3), .CNT_W(CW)) u_dut3 (
        .clk(clk), .rst(rst), .i_start(i_start), .i_data_in(i_data),
        .o_det_in(det_in3), .i_det_y(det_y3), .o_busy(busy3), .o_done(done3),
        .o_match_vec(vec3), .o_match_cnt(cnt3)
    );

    function automatic int popcount(input logic [W-1:0] w);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(w[i]);
        return n;
    endfunction

    // Expected matches when the serial stream w (MSB first) feeds a "101" detector.
    function automatic logic [W-1:0] ref_101(input logic [W-1:0] w);
        logic [W-1:0] r = '0;
        for (int k = 2; k < W; k++)
            if (w[W-1-(k-2)] && !w[W-1-(k-1)] && w[W-1-k]) r[W-1-k] = 1'b1;
        return r;
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue start for the cycle ahead, then observe ncyc cycles; cycle c is the
    // c-th cycle after the one in which start was accepted.
    task automatic run_word(input logic [W-1:0] w, input int ncyc,
                            input int extra1, input int extra2, input bit hold);
        lat1 = -1; lat3 = -1; nd1 = 0; nd3 = 0; done1_at2 = -1;
        saw_det1 = 1'b0; busy_bad = 1'b0;
        i_data  = w;
        i_start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            i_start = hold || (c == extra1) || (c == extra2);
            i_data  = W'($urandom);
            if (det_in1) saw_det1 = 1'b1;
            if (done1) begin
                nd1++;
                if (lat1 < 0) lat1 = c;
                else if (done1_at2 < 0) done1_at2 = c;
            end
            if (done3) begin
                nd3++;
                if (lat3 < 0) lat3 = c;
            end
            if (c <= W + 1 && !busy1) busy_bad = 1'b1;
            if (c == W + 2 && busy1) busy_bad = 1'b1;
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b1; i_data = 16'hFFFF;
        det_mode = 1'b0; glitch = 1'b0;
        wait_cycles(3);
        n_checks++;
        if ({busy1, done1, det_in1, vec1, cnt1} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: got busy=%b done=%b det_in=%b vec=%h cnt=%0d required all 0",
                     busy1, done1, det_in1, vec1, cnt1);
        end
        n_checks++;
        if ({busy3, done3, det_in3, vec3, cnt3} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut3: got busy=%b done=%b det_in=%b vec=%h cnt=%0d required all 0",
                     busy3, done3, det_in3, vec3, cnt3);
        end
        rst = 1'b0; i_start = 1'b0;
        wait_cycles(3);
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_beats_start: got busy=%b required 0", busy1);
        end
    endtask

    task automatic test_a5c3();
        run_word(16'hA5C3, 24, 0, 0, 1'b0);
        n_checks++; if (lat1 !== W + 2) begin n_fail++; $display("FAIL a5c3_latency: got %0d required %0d", lat1, W + 2); end
        n_checks++; if (nd1 !== 1) begin n_fail++; $display("FAIL a5c3_done_count: got %0d required 1", nd1); end
        n_checks++; if (vec1 !== 16'hA5C3) begin n_fail++; $display("FAIL a5c3_vec: got %h required a5c3", vec1); end
        n_checks++; if (int'(cnt1) !== popcount(16'hA5C3)) begin n_fail++; $display("FAIL a5c3_cnt: got %0d required %0d", cnt1, popcount(16'hA5C3)); end
        n_checks++; if (busy_bad !== 1'b0) begin n_fail++; $display("FAIL a5c3_busy: got bad=%b required 0", busy_bad); end
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL a5c3_done_after: got %b required 0", done1); end
    endtask

    task automatic test_zero_ones();
        run_word(16'h0000, 24, 0, 0, 1'b0);
        n_checks++; if (saw_det1 !== 1'b0) begin n_fail++; $display("FAIL zero_det_in: got high=%b required 0", saw_det1); end
        n_checks++; if ({vec1, cnt1} !== '0) begin n_fail++; $display("FAIL zero_result: got vec=%h cnt=%0d required 0", vec1, cnt1); end
        n_checks++; if (nd1 !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d required 1", nd1); end
        run_word(16'hFFFF, 24, 0, 0, 1'b0);
        n_checks++; if (cnt1 !== 5'd16) begin n_fail++; $display("FAIL ones_cnt: got %0d required 16", cnt1); end
        n_checks++; if (vec1 !== 16'hFFFF) begin n_fail++; $display("FAIL ones_vec: got %h required ffff", vec1); end
    endtask

    task automatic test_latency3();
        glitch = 1'b1;
        wait_cycles(2);
        glitch = 1'b0;
        run_word(16'h8001, 24, 0, 0, 1'b0);
        n_checks++; if (lat3 !== W + 4) begin n_fail++; $display("FAIL lat3_latency: got %0d required %0d", lat3, W + 4); end
        n_checks++; if (vec3 !== 16'h8001) begin n_fail++; $display("FAIL lat3_vec: got %h required 8001", vec3); end
        n_checks++; if (cnt3 !== 5'd2) begin n_fail++; $display("FAIL lat3_cnt: got %0d required 2", cnt3); end
        n_checks++; if (nd3 !== 1) begin n_fail++; $display("FAIL lat3_done_count: got %0d required 1", nd3); end
        glitch = 1'b1;
        wait_cycles(3);
        glitch = 1'b0;
        wait_cycles(1);
        n_checks++; if (vec3 !== 16'h8001 || cnt3 !== 5'd2) begin n_fail++; $display("FAIL idle_glitch_dut3: got vec=%h cnt=%0d required 8001/2", vec3, cnt3); end
        n_checks++; if (vec1 !== 16'h8001 || cnt1 !== 5'd2) begin n_fail++; $display("FAIL idle_glitch_dut1: got vec=%h cnt=%0d required 8001/2", vec1, cnt1); end
    endtask

    task automatic test_extra_start();
        run_word(16'h3C5A, 26, 5, W + 1, 1'b0);
        n_checks++; if (nd1 !== 1) begin n_fail++; $display("FAIL extra_start_done_count: got %0d required 1", nd1); end
        n_checks++; if (lat1 !== W + 2) begin n_fail++; $display("FAIL extra_start_latency: got %0d required %0d", lat1, W + 2); end
        n_checks++; if (vec1 !== 16'h3C5A) begin n_fail++; $display("FAIL extra_start_vec: got %h required 3c5a", vec1); end
        n_checks++; if (nd3 !== 1) begin n_fail++; $display("FAIL extra_start_done3: got %0d required 1", nd3); end
    endtask

    task automatic test_back_to_back();
        run_word(16'h1234, 40, 0, 0, 1'b1);
        n_checks++; if (lat1 !== W + 2) begin n_fail++; $display("FAIL b2b_first_done: got %0d required %0d", lat1, W + 2); end
        n_checks++; if (done1_at2 !== 2 * (W + 2) + 1) begin n_fail++; $display("FAIL b2b_second_done: got %0d required %0d", done1_at2, 2 * (W + 2) + 1); end
        n_checks++; if (nd1 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 2", nd1); end
        wait_cycles(40);
    endtask

    task automatic test_reset_mid();
        int nd;
        i_data = 16'hFFFF; i_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        n_checks++; if (cnt1 !== 5'd5 || vec1 !== 16'hF800) begin n_fail++; $display("FAIL mid_partial: got vec=%h cnt=%0d required f800/5", vec1, cnt1); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy1, done1, det_in1, vec1, cnt1, busy3, vec3, cnt3} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got busy=%b vec=%h cnt=%0d busy3=%b vec3=%h cnt3=%0d required all 0",
                     busy1, vec1, cnt1, busy3, vec3, cnt3);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done1 || done3) nd++;
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses required 0", nd); end
        run_word(16'h00F0, 24, 0, 0, 1'b0);
        n_checks++; if (vec1 !== 16'h00F0) begin n_fail++; $display("FAIL after_reset_vec: got %h required 00f0", vec1); end
        n_checks++; if (vec3 !== 16'h00F0) begin n_fail++; $display("FAIL after_reset_vec3: got %h required 00f0", vec3); end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int t = 0; t < 6; t++) begin
            w = W'($urandom);
            run_word(w, 24, 0, 0, 1'b0);
            n_checks++; if (vec1 !== w || int'(cnt1) !== popcount(w)) begin n_fail++; $display("FAIL random_dut1: got vec=%h cnt=%0d required %h/%0d", vec1, cnt1, w, popcount(w)); end
            n_checks++; if (vec3 !== w || int'(cnt3) !== popcount(w)) begin n_fail++; $display("FAIL random_dut3: got vec=%h cnt=%0d required %h/%0d", vec3, cnt3, w, popcount(w)); end
            n_checks++; if (lat1 !== W + 2 || lat3 !== W + 4) begin n_fail++; $display("FAIL random_latency: got %0d/%0d required %0d/%0d", lat1, lat3, W + 2, W + 4); end
        end
    endtask

    task automatic test_detector();
        logic [W-1:0] w;
        logic [W-1:0] exp;
        det_mode = 1'b1;
        for (int t = 0; t < 5; t++) begin
            w = (t == 0) ? 16'b1101_0011_1010_0110 : W'($urandom);
            exp = ref_101(w);
            run_word(w, 24, 0, 0, 1'b0);
            n_checks++; if (vec1 !== exp) begin n_fail++; $display("FAIL detector_vec: word=%h got %h required %h", w, vec1, exp); end
            n_checks++; if (int'(cnt1) !== popcount(exp)) begin n_fail++; $display("FAIL detector_cnt: word=%h got %0d required %0d", w, cnt1, popcount(exp)); end
        end
        det_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_a5c3();
        test_zero_ones();
        test_latency3();
        test_extra_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_detector();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
